alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: most opcodes complete in one cycle, MUL and DIV iterate one bit per cycle.
// Outputs are registered and change only on the edge that raises done.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           op,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 carry,
    output logic                 zero,
    output logic                 dz
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_GT   = 4'd12;
    localparam logic [3:0] OP_LT   = 4'd13;
    localparam logic [3:0] OP_EQ   = 4'd14;
    localparam logic [3:0] OP_INC  = 4'd15;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [3:0]           op_reg;
    logic [2*WIDTH-1:0]   opa;
    logic [WIDTH-1:0]     opb;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic                 accept, is_multi, last_step;
    logic [WIDTH:0]       sum, inc_sum, trial, trial_sub;
    logic [SHW-1:0]       sh;
    logic [2*WIDTH-1:0]   shl_wide, shr_wide;
    logic [2*WIDTH-1:0]   sc_result, mul_next, div_next, iter_next;
    logic                 sc_carry, sc_dz;

    assign in_ready  = (state == IDLE);
    assign done      = (state == DONE);
    assign accept    = (state == IDLE) && start;
    assign is_multi  = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = is_multi ? RUN : DONE;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sum      = {1'b0, a} + {1'b0, b};
    assign inc_sum  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    assign sh       = b[SHW-1:0];
    // Shift through a double-width window so the bits that fall off land in the other half.
    assign shl_wide = {{WIDTH{1'b0}}, a} << sh;
    assign shr_wide = {a, {WIDTH{1'b0}}} >> sh;

    always_comb begin
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_dz     = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result = {{(WIDTH-1){1'b0}}, sum};
                sc_carry  = sum[WIDTH];
            end
            OP_SUB: begin
                sc_result = {{(WIDTH-1){1'b0}}, (a >= b), a - b};
                sc_carry  = (a >= b);
            end
            OP_DIV: begin
                sc_result = {a, {WIDTH{1'b1}}};
                sc_dz     = 1'b1;
            end
            OP_AND:  sc_result = {{WIDTH{1'b0}}, a & b};
            OP_OR:   sc_result = {{WIDTH{1'b0}}, a | b};
            OP_XOR:  sc_result = {{WIDTH{1'b0}}, a ^ b};
            OP_NAND: sc_result = {{WIDTH{1'b0}}, ~(a & b)};
            OP_NOR:  sc_result = {{WIDTH{1'b0}}, ~(a | b)};
            OP_XNOR: sc_result = {{WIDTH{1'b0}}, ~(a ^ b)};
            OP_SHL: begin
                sc_result = {{WIDTH{1'b0}}, shl_wide[WIDTH-1:0]};
                sc_carry  = |shl_wide[2*WIDTH-1:WIDTH];
            end
            OP_SHR: begin
                sc_result = {{WIDTH{1'b0}}, shr_wide[2*WIDTH-1:WIDTH]};
                sc_carry  = |shr_wide[WIDTH-1:0];
            end
            OP_GT: sc_result = {{(2*WIDTH-1){1'b0}}, (a > b)};
            OP_LT: sc_result = {{(2*WIDTH-1){1'b0}}, (a < b)};
            OP_EQ: sc_result = {{(2*WIDTH-1){1'b0}}, (a == b)};
            OP_INC: begin
                sc_result = {{(WIDTH-1){1'b0}}, inc_sum};
                sc_carry  = inc_sum[WIDTH];
            end
            default: sc_result = '0;
        endcase
    end

    // DIV keeps {remainder, quotient} in acc; bit WIDTH of the trial difference is the borrow.
    assign mul_next  = opb[0] ? (acc + opa) : acc;
    assign trial     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign trial_sub = trial - {1'b0, opb};
    assign div_next  = trial_sub[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                        : {trial_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign iter_next = (op_reg == OP_MUL) ? mul_next : div_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            op_reg <= op;
            opa    <= {{WIDTH{1'b0}}, a};
            opb    <= b;
            acc    <= (op == OP_DIV) ? {{WIDTH{1'b0}}, a} : '0;
            cnt    <= '0;
            if (!is_multi) begin
                result <= sc_result;
                carry  <= sc_carry;
                zero   <= (sc_result == '0);
                dz     <= sc_dz;
            end
        end else if (state == RUN) begin
            acc <= iter_next;
            cnt <= cnt + CW'(1);
            if (op_reg == OP_MUL) begin
                opa <= opa << 1;
                opb <= opb >> 1;
            end
            if (last_step) begin
                result <= iter_next;
                carry  <= 1'b0;
                zero   <= (iter_next == '0);
                dz     <= 1'b0;
            end
        end
    end

endmodule
